// File: rtl/gf2_ge_array.sv
// Pipelined GF(2) Gaussian-elimination array: ROWS stages, each owning one basis slot.
// Optional GF2GE_DROP_CNT_EN adds a saturating count of rows that reduced to zero.
module gf2_ge_array #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [COLS-1:0]            in_row,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  rank,
  output logic                       full_rank,
  output logic                       overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS-1:0]            out_row,
  output logic [$clog2(COLS)-1:0]    out_pivot,
`ifdef GF2GE_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic                       out_used
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int PW = $clog2(COLS);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StRead} state_e;

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic [IW-1:0]   drain_cnt_q;
  logic [IW-1:0]   rd_idx_q;
  logic            overflow_q;

  logic [ROWS-1:0] p_vld_q;
  logic [COLS-1:0] p_res_q [ROWS];

  logic [ROWS-1:0] slot_used_q;
  logic [COLS-1:0] slot_row_q [ROWS];
  logic [PW-1:0]   slot_piv_q [ROWS];

  // Stage i output: feeds p(i+1), or the overflow check for the last stage.
  logic [ROWS-1:0] nxt_vld;
  logic [COLS-1:0] nxt_res [ROWS];
  logic [ROWS-1:0] store_en;
  logic [PW-1:0]   store_piv [ROWS];

  logic            clear;
  logic            accept;
  logic [RW-1:0]   rank_cnt;

  function automatic logic [PW-1:0] msb_idx(input logic [COLS-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int b = 0; b < COLS; b++) begin
      if (v[b]) r = PW'(b);
    end
    return r;
  endfunction

  assign clear  = (state_q == StIdle) && start;
  assign accept = (state_q == StLoad) && in_valid;

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      nxt_vld[i]   = 1'b0;
      nxt_res[i]   = '0;
      store_en[i]  = 1'b0;
      store_piv[i] = msb_idx(p_res_q[i]);
      if (p_vld_q[i]) begin
        if (slot_used_q[i]) begin
          nxt_vld[i] = 1'b1;
          nxt_res[i] = p_res_q[i][slot_piv_q[i]] ? (p_res_q[i] ^ slot_row_q[i]) : p_res_q[i];
        end else if (|p_res_q[i]) begin
          store_en[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (in_valid && in_last) state_d = StDrain;
      StDrain: begin
        if (drain_cnt_q == IW'(ROWS - 1)) begin
          state_d = StRead;
          done_d  = 1'b1;
        end
      end
      StRead:  if (out_ready && (rd_idx_q == IW'(ROWS - 1))) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
      rd_idx_q    <= '0;
      overflow_q  <= 1'b0;
      p_vld_q     <= '0;
      slot_used_q <= '0;
      for (int i = 0; i < ROWS; i++) begin
        p_res_q[i]    <= '0;
        slot_row_q[i] <= '0;
        slot_piv_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
      if (clear) begin
        rd_idx_q    <= '0;
        overflow_q  <= 1'b0;
        p_vld_q     <= '0;
        slot_used_q <= '0;
        for (int i = 0; i < ROWS; i++) begin
          slot_row_q[i] <= '0;
          slot_piv_q[i] <= '0;
        end
      end else begin
        if (state_q == StRead && out_ready) rd_idx_q <= rd_idx_q + 1'b1;
        p_vld_q[0] <= accept;
        p_res_q[0] <= in_row;
        for (int i = 0; i < ROWS - 1; i++) begin
          p_vld_q[i+1] <= nxt_vld[i];
          p_res_q[i+1] <= nxt_res[i];
        end
        for (int i = 0; i < ROWS; i++) begin
          if (store_en[i]) begin
            slot_used_q[i] <= 1'b1;
            slot_row_q[i]  <= p_res_q[i];
            slot_piv_q[i]  <= store_piv[i];
          end
        end
        if (nxt_vld[ROWS-1] && (|nxt_res[ROWS-1])) overflow_q <= 1'b1;
      end
    end
  end

`ifdef GF2GE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [9:0] drop_sum;

  always_comb begin
    drop_sum = {2'b00, drop_cnt_q};
    for (int i = 0; i < ROWS; i++) begin
      if (p_vld_q[i] && !slot_used_q[i] && !(|p_res_q[i])) drop_sum = drop_sum + 10'd1;
    end
    drop_cnt_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        drop_cnt_q <= '0;
    else if (clear) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  always_comb begin
    rank_cnt = '0;
    for (int i = 0; i < ROWS; i++) rank_cnt = rank_cnt + RW'(slot_used_q[i]);
  end

  assign in_ready  = (state_q == StLoad);
  assign done      = done_q;
  assign rank      = rank_cnt;
  assign full_rank = (rank_cnt == RW'(ROWS));
  assign overflow  = overflow_q;
  assign out_valid = (state_q == StRead);
  assign out_row   = out_valid ? slot_row_q[rd_idx_q] : '0;
  assign out_pivot = out_valid ? slot_piv_q[rd_idx_q] : '0;
  assign out_used  = out_valid ? slot_used_q[rd_idx_q] : 1'b0;

endmodule

// File: tb/tb_gf2_ge_array.sv
// Self-checking bench for gf2_ge_array: directed cases plus random matrices checked
// against a sequential elimination model.
module tb_gf2_ge_array;
  localparam int ROWS = 4;
  localparam int COLS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [COLS-1:0] in_row = '0;
  logic            out_ready = 1'b0;
  logic            in_ready, done, full_rank, overflow, out_valid, out_used;
  logic [2:0]      rank;
  logic [COLS-1:0] out_row;
  logic [2:0]      out_pivot;
`ifdef GF2GE_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  gf2_ge_array #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_row    (in_row),
    .done      (done),
    .rank      (rank),
    .full_rank (full_rank),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_pivot (out_pivot),
`ifdef GF2GE_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .out_used  (out_used)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mat [$];
  logic [7:0] m_row  [ROWS];
  int         m_piv  [ROWS];
  bit         m_used [ROWS];
  bit         m_ovf;
  int         m_drop;
  int         m_rank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rows enter one at a time; each walks the slots in order until stored, dropped or out.
  task automatic model_run();
    logic [7:0] r;
    bit placed;
    m_ovf = 0; m_drop = 0; m_rank = 0;
    for (int i = 0; i < ROWS; i++) begin
      m_row[i] = '0; m_piv[i] = 0; m_used[i] = 0;
    end
    foreach (mat[k]) begin
      r = mat[k];
      placed = 0;
      for (int i = 0; i < ROWS; i++) begin
        if (m_used[i]) begin
          if (r[m_piv[i]]) r = r ^ m_row[i];
        end else begin
          if (r != 0) begin
            m_row[i] = r;
            m_used[i] = 1;
            m_rank++;
            for (int b = 0; b < COLS; b++) if (r[b]) m_piv[i] = b;
          end else begin
            m_drop++;
          end
          placed = 1;
          break;
        end
      end
      if (!placed && r != 0) m_ovf = 1;
    end
  endtask

  task automatic feed(input bit gaps, input bit poke_start);
    start = 1'b1;
    step();
    start = 1'b0;
    check("in_ready_load", 32'(in_ready), 32'd1);
    if (poke_start) begin
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      check("start_ignored_in_load", 32'(in_ready), 32'd1);
    end
    foreach (mat[k]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_row   = mat[k];
      in_last  = (k == mat.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run(input int stall_slot, input bit gaps, input bit poke_start);
    int k;
    model_run();
    feed(gaps, poke_start);
    k = 0;
    while (done !== 1'b1 && k < 4 * ROWS) begin
      step();
      k++;
    end
    check("done_latency", 32'(k), 32'(ROWS));
    check("rank", 32'(rank), 32'(m_rank));
    check("full_rank", 32'(full_rank), 32'(m_rank == ROWS));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef GF2GE_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    step();
    check("done_pulse", 32'(done), 32'd0);
    for (int s = 0; s < ROWS; s++) begin
      if (s == stall_slot) begin
        for (int c = 0; c < 3; c++) begin
          check("stall_out_row", 32'(out_row), 32'(m_row[s]));
          step();
        end
        check("stall_out_pivot", 32'(out_pivot), 32'(m_piv[s]));
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_row", 32'(out_row), 32'(m_row[s]));
      check("out_pivot", 32'(out_pivot), 32'(m_piv[s]));
      check("out_used", 32'(out_used), 32'(m_used[s]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_rank_hold", 32'(rank), 32'(m_rank));
  endtask

  initial begin
    int n;
    bit saw_done;
    logic [7:0] v;

    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rank", 32'(rank), 32'd0);
    check("rst_full_rank", 32'(full_rank), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_row", 32'(out_row), 32'd0);
    check("rst_out_pivot", 32'(out_pivot), 32'd0);
    check("rst_out_used", 32'(out_used), 32'd0);
    rst = 1'b0;
    step();

    mat = '{8'h80, 8'h40, 8'h20, 8'h10};
    run(-1, 0, 0);
    mat = '{8'hC0, 8'h40, 8'h80, 8'h01};
    run(-1, 0, 0);
    check("req029_slot2", 32'(m_row[2]), 32'h01);
    mat = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
    run(-1, 0, 0);
    mat = '{8'h93, 8'h5A, 8'h21, 8'h07};
    run(1, 0, 0);

    // Reset while draining: no done may follow, outputs return to reset values.
    mat = '{8'h80, 8'h40, 8'h20, 8'h10};
    feed(0, 0);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_rank", 32'(rank), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < ROWS + 4; c++) begin
      step();
      if (done === 1'b1 || out_valid === 1'b1) saw_done = 1;
    end
    check("no_done_after_rst", 32'(saw_done), 32'd0);
    run(-1, 0, 0);

    // Row offered in IDLE must be ignored; start in LOAD ignored.
    in_valid = 1'b1;
    in_row   = 8'hFF;
    in_last  = 1'b1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    check("idle_no_done", 32'(done), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    mat = '{8'h03, 8'h05};
    run(-1, 0, 1);

    for (int t = 0; t < 25; t++) begin
      mat.delete();
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        v = 8'($urandom_range(0, 255));
        if (j >= 2 && $urandom_range(0, 3) == 0) v = mat[0] ^ mat[j-1];
        if ($urandom_range(0, 9) == 0) v = 8'h00;
        mat.push_back(v);
      end
      run(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, ROWS - 1)) : -1, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
